vga_rx_monitor: RTL

//   Receive end of the VGA PMOD bus driven by the game top: unpacks the 8-bit
//   pin word plus de, recovers pixel coordinates, checks 640x480 timing, and

---
 rtl/vga_rx_monitor_pkg.sv | 30 +++
 rtl/vga_sync_edge.sv | 24 ++
 rtl/vga_rx_monitor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_rx_monitor_pkg.sv
// rtl/vga_rx_monitor_pkg.sv - VGA PMOD pin map, 640x480 timing constants, monitor FSM states
package vga_rx_monitor_pkg;

  localparam int HS_BIT = 7;
  localparam int B0_BIT = 6;
  localparam int G0_BIT = 5;
  localparam int R0_BIT = 4;
  localparam int VS_BIT = 3;
  localparam int B1_BIT = 2;
  localparam int G1_BIT = 1;
  localparam int R1_BIT = 0;

  localparam int H_ACTIVE_640 = 640;
  localparam int V_ACTIVE_480 = 480;
  localparam int H_TOTAL_800  = 800;
  localparam int V_TOTAL_525  = 525;

  localparam logic [9:0] CNT_MAX = 10'h3ff;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - registers one sync/enable pin and flags its leading and trailing edges
module vga_sync_edge #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic active,
  output logic lead,
  output logic trail
);

  logic act_q;

  assign active = sig ^ ACTIVE_LOW;
  assign lead   = active & ~act_q;
  assign trail  = ~active & act_q;

  always_ff @(posedge clk) begin
    if (!rst_n) act_q <= 1'b0;
    else        act_q <= active;
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA PMOD receiver: coordinate recovery, timing lock and colour probe
module vga_rx_monitor
  import vga_rx_monitor_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int V_ACTIVE = V_ACTIVE_480,
  parameter int H_TOTAL  = H_TOTAL_800,
  parameter int V_TOTAL  = V_TOTAL_525,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_pins,
  input  logic       de,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_valid,
  output logic [5:0] rgb,
  output logic       locked,
  output logic       frame_done,
  output logic [5:0] probe_rgb,
  output logic       probe_hit,
  output logic       timing_err
);

  localparam logic [9:0] H_ACT_L = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);
  localparam logic [9:0] H_TOT_L = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT_L = 10'(V_TOTAL);

  logic hs_act, hs_lead, hs_trail;
  logic vs_act, vs_lead, vs_trail;
  logic de_act, de_rise, de_fall;
  logic unused_edges;

  vga_sync_edge #(.ACTIVE_LOW(SYNC_NEG)) u_hs (
    .clk(clk), .rst_n(rst_n), .sig(vga_pins[HS_BIT]),
    .active(hs_act), .lead(hs_lead), .trail(hs_trail));

  vga_sync_edge #(.ACTIVE_LOW(SYNC_NEG)) u_vs (
    .clk(clk), .rst_n(rst_n), .sig(vga_pins[VS_BIT]),
    .active(vs_act), .lead(vs_lead), .trail(vs_trail));

  vga_sync_edge #(.ACTIVE_LOW(1'b0)) u_de (
    .clk(clk), .rst_n(rst_n), .sig(de),
    .active(de_act), .lead(de_rise), .trail(de_fall));

  assign unused_edges = ^{hs_act, hs_trail, vs_trail};

  logic [9:0] hcnt, lcnt, pcnt;
  logic [9:0] probe_x_l, probe_y_l;
  logic [9:0] y_upd, l_upd;
  logic [5:0] rgb_in;
  logic       fail, fail_flag, probe_match;
  mon_state_t state;

  assign rgb_in = {vga_pins[R1_BIT], vga_pins[R0_BIT], vga_pins[G1_BIT],
                   vga_pins[G0_BIT], vga_pins[B1_BIT], vga_pins[B0_BIT]};

  // Line bookkeeping lands before the frame check when hsync and vsync lead together.
  assign y_upd = de_fall ? sat_inc(y) : y;
  assign l_upd = hs_lead ? sat_inc(lcnt) : lcnt;

  assign fail = (de_fall && pcnt != H_ACT_L)
              || (hs_lead && hcnt != H_TOT_L)
              || (vs_act && de_act)
              || (vs_lead && (y_upd != V_ACT_L || l_upd != V_TOT_L));

  assign probe_match = pix_valid && (x == probe_x_l) && (y == probe_y_l);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      pix_valid  <= 1'b0;
      rgb        <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      probe_rgb  <= '0;
      probe_hit  <= 1'b0;
      timing_err <= 1'b0;
      hcnt       <= '0;
      lcnt       <= '0;
      pcnt       <= '0;
      probe_x_l  <= '0;
      probe_y_l  <= '0;
      fail_flag  <= 1'b0;
      state      <= ST_SEARCH;
    end else begin
      pix_valid <= de_act;
      rgb       <= rgb_in;
      if (de_rise)     x <= '0;
      else if (de_act) x <= sat_inc(x);
      y    <= vs_lead ? '0 : y_upd;
      lcnt <= vs_lead ? '0 : l_upd;
      hcnt <= hs_lead ? 10'd1 : sat_inc(hcnt);
      pcnt <= hs_lead ? {9'd0, de_act} : (de_act ? sat_inc(pcnt) : pcnt);
      if (vs_lead) begin
        probe_x_l <= probe_x;
        probe_y_l <= probe_y;
      end
      probe_hit <= probe_match;
      if (probe_match) probe_rgb <= rgb;
      frame_done <= (state == ST_LOCKED) && vs_lead;
      timing_err <= (state == ST_LOCKED) && fail;

      case (state)
        ST_SEARCH: begin
          if (vs_lead) begin
            state     <= ST_ALIGN;
            fail_flag <= 1'b0;
          end
        end
        ST_ALIGN: begin
          if (vs_lead) begin
            fail_flag <= 1'b0;
            if (!(fail_flag || fail)) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end else begin
            fail_flag <= fail_flag | fail;
          end
        end
        ST_LOCKED: begin
          if (fail) begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
